filt_sample_fifo: RTL and testbench

FILT_SAMPLE_FIFO -- requirements
Module: filt_sample_fifo

---
 rtl/filt_sample_fifo.sv | 126 ++++++++++++
 tb/tb_filt_sample_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/filt_sample_fifo.sv
// Sample FIFO between a clock-enabled filter and a ready/valid consumer.
// Circular-buffer storage feeds a registered output stage, with a bypass path when storage is empty.
module filt_sample_fifo #(
    parameter int MSBI       = 7,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK21M,
    input  logic                  RESET_N,
    input  logic                  CLKENA,
    input  logic [MSBI:0]         IDATA,
    input  logic                  OREADY,
    output logic                  OVALID,
    output logic [MSBI:0]         ODATA,
    output logic [DEPTH_LOG2:0]   LEVEL,
    output logic                  OVF,
    input  logic                  CLR_OVF
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [MSBI:0]         mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
    logic [DEPTH_LOG2:0]   count_reg, count_next;
    logic                  ovalid_reg, ovalid_next;
    logic                  ovf_reg, ovf_next;
    logic                  armed_reg;
    logic [MSBI:0]         odata_reg;

    logic out_free;
    logic push_req;
    logic is_empty;
    logic is_full;
    logic do_pop;
    logic do_bypass;
    logic do_store;
    logic do_drop;

    // armed_reg is low during the release cycle so a strobe coinciding with reset release is ignored
    always_comb begin
        out_free  = !ovalid_reg || OREADY;
        push_req  = CLKENA && armed_reg;
        is_empty  = (count_reg == '0);
        is_full   = (count_reg == FULL_COUNT);
        do_pop    = !is_empty && out_free;
        do_bypass = push_req && is_empty && out_free;
        do_store  = push_req && !do_bypass && (!is_full || do_pop);
        do_drop   = push_req && !do_bypass && is_full && !do_pop;
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        ovalid_next = ovalid_reg;
        ovf_next    = ovf_reg;

        if (do_store) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end

        unique case ({do_store, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        // A refill (pop or bypass) keeps OVALID high across a completed transfer
        if (do_pop || do_bypass) begin
            ovalid_next = 1'b1;
        end else if (out_free) begin
            ovalid_next = 1'b0;
        end

        // Set has priority over clear
        if (do_drop) begin
            ovf_next = 1'b1;
        end else if (CLR_OVF) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge CLK21M or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovalid_reg <= 1'b0;
            ovf_reg    <= 1'b0;
            armed_reg  <= 1'b0;
            odata_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            ovalid_reg <= ovalid_next;
            ovf_reg    <= ovf_next;
            armed_reg  <= 1'b1;
            if (do_pop) begin
                odata_reg <= mem[rd_ptr_reg];
            end else if (do_bypass) begin
                odata_reg <= IDATA;
            end
        end
    end

    // Storage has no reset so it can map onto block RAM; at full, a same-cycle write
    // and read hit one address and the read returns the older sample.
    always_ff @(posedge CLK21M) begin
        if (do_store) begin
            mem[wr_ptr_reg] <= IDATA;
        end
    end

    assign OVALID = ovalid_reg;
    assign ODATA  = odata_reg;
    assign LEVEL  = count_reg;
    assign OVF    = ovf_reg;

endmodule

// File: tb/tb_filt_sample_fifo.sv
// Self-checking bench for filt_sample_fifo: directed vector table, corner-case sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_filt_sample_fifo;

    localparam int MSBI       = 7;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 2 ** DEPTH_LOG2;

    logic                CLK21M;
    logic                RESET_N;
    logic                CLKENA;
    logic [MSBI:0]       IDATA;
    logic                OREADY;
    logic                OVALID;
    logic [MSBI:0]       ODATA;
    logic [DEPTH_LOG2:0] LEVEL;
    logic                OVF;
    logic                CLR_OVF;

    int checks = 0;
    int errors = 0;

    filt_sample_fifo #(
        .MSBI       (MSBI),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .CLK21M  (CLK21M),
        .RESET_N (RESET_N),
        .CLKENA  (CLKENA),
        .IDATA   (IDATA),
        .OREADY  (OREADY),
        .OVALID  (OVALID),
        .ODATA   (ODATA),
        .LEVEL   (LEVEL),
        .OVF     (OVF),
        .CLR_OVF (CLR_OVF)
    );

    initial begin
        CLK21M = 1'b0;
        forever #5 CLK21M = ~CLK21M;
    end

    // Reference model: storage as a queue, output register as a valid flag plus data
    logic [MSBI:0] mq[$];
    bit            m_ov;
    logic [MSBI:0] m_od;
    bit            m_ovf;
    bit            m_armed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov    = 1'b0;
        m_od    = '0;
        m_ovf   = 1'b0;
        m_armed = 1'b0;
    endtask

    task automatic model_step(input bit ce, input logic [MSBI:0] d, input bit rdy, input bit clr);
        bit free;
        bit popd;
        bit drop;
        int n;
        free = !m_ov || rdy;
        n    = mq.size();
        popd = (n > 0) && free;
        drop = 1'b0;
        if (popd) begin
            m_od = mq.pop_front();
            m_ov = 1'b1;
        end else if (free) begin
            m_ov = 1'b0;
        end
        if (ce && m_armed) begin
            if (n == 0 && free) begin
                m_od = d;
                m_ov = 1'b1;
            end else if (n < DEPTH || popd) begin
                mq.push_back(d);
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_armed = 1'b1;
    endtask

    // Entered and left at posedge+1; inputs held until the next call
    task automatic cycle(input bit ce, input logic [MSBI:0] d, input bit rdy, input bit clr);
        CLKENA  = ce;
        IDATA   = d;
        OREADY  = rdy;
        CLR_OVF = clr;
        @(posedge CLK21M);
        model_step(ce, d, rdy, clr);
        #1;
        chk("model_ovalid", OVALID, m_ov);
        chk("model_level", LEVEL, mq.size());
        chk("model_ovf", OVF, m_ovf);
        if (m_ov) chk("model_odata", ODATA, m_od);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        CLKENA  = 1'b0;
        #1;
        chk("rst_ovalid", OVALID, 0);
        chk("rst_level", LEVEL, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_odata", ODATA, 0);
        model_reset();
        @(posedge CLK21M);
        @(posedge CLK21M);
        #1;
        RESET_N = 1'b1;
    endtask

    typedef struct {
        bit            ce;
        logic [MSBI:0] d;
        bit            rdy;
        bit            exp_ov;
        logic [MSBI:0] exp_od;
        int            exp_lvl;
    } vec_t;

    vec_t vt[13];

    initial begin
        logic [MSBI:0] last;
        int            pct;

        vt[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 0};
        vt[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};
        vt[2]  = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 0};
        vt[3]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1};
        vt[4]  = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 2};
        vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1};
        vt[6]  = '{1'b1, 8'h44, 1'b1, 1'b1, 8'h33, 1};
        vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 0};
        vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};
        vt[9]  = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h55, 0};
        vt[10] = '{1'b1, 8'h66, 1'b1, 1'b1, 8'h66, 0};
        vt[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 0};
        vt[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};

        RESET_N = 1'b1;
        CLKENA  = 1'b0;
        IDATA   = '0;
        OREADY  = 1'b0;
        CLR_OVF = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Strobe in the release cycle must be ignored
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        chk("release_ignored", OVALID, 0);

        for (int i = 0; i < 13; i++) begin
            cycle(vt[i].ce, vt[i].d, vt[i].rdy, 1'b0);
            chk("vec_ovalid", OVALID, vt[i].exp_ov);
            if (vt[i].exp_ov) chk("vec_odata", ODATA, vt[i].exp_od);
            chk("vec_level", LEVEL, vt[i].exp_lvl);
            $display("vec %0d ce=%0b d=%02h rdy=%0b -> ovalid=%0b odata=%02h level=%0d",
                     i, vt[i].ce, vt[i].d, vt[i].rdy, OVALID, ODATA, LEVEL);
        end

        // Fill past capacity with the consumer stalled, then drain in order
        for (int i = 1; i <= 18; i++) cycle(1'b1, MSBI'(i), 1'b0, 1'b0);
        chk("fill_level", LEVEL, 16);
        chk("fill_ovf", OVF, 1);
        chk("fill_ovalid", OVALID, 1);
        chk("fill_odata", ODATA, 8'h01);
        for (int v = 1; v <= 17; v++) begin
            chk("drain_ovalid", OVALID, 1);
            chk("drain_odata", ODATA, v);
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_done", OVALID, 0);
        chk("drain_ovf_sticky", OVF, 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk("ovf_cleared", OVF, 0);
        $display("seq fill/overflow/drain done");

        // Push and pop together at full
        for (int i = 1; i <= 17; i++) cycle(1'b1, MSBI'(8'h20 + i), 1'b0, 1'b0);
        chk("full_level", LEVEL, 16);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("full_pushpop_level", LEVEL, 16);
        chk("full_pushpop_ovf", OVF, 0);
        cycle(1'b1, 8'hEF, 1'b0, 1'b1);
        chk("set_wins_ovf", OVF, 1);
        chk("set_wins_level", LEVEL, 16);
        last = '0;
        for (int k = 0; k < 40; k++) begin
            if (!OVALID) break;
            last = ODATA;
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("full_last", last, 8'hEE);
        chk("full_drained", OVALID, 0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        $display("seq full push+pop done");

        // Backpressure holds the output register
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("bp_first", ODATA, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, MSBI'(8'h40 + i), 1'b0, 1'b0);
            chk("bp_hold", ODATA, 8'h3C);
            chk("bp_level", LEVEL, i + 1);
        end
        repeat (7) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_drained", OVALID, 0);
        $display("seq backpressure done");

        // Steady streaming at level 3 so the pointers wrap repeatedly
        for (int i = 0; i < 4; i++) cycle(1'b1, MSBI'(8'h70 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, MSBI'(8'h80 + i), 1'b1, 1'b0);
            chk("wrap_level", LEVEL, 3);
        end
        repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_drained", OVALID, 0);
        $display("seq wrap done");

        // Reset in the middle of activity
        for (int i = 1; i <= 18; i++) cycle(1'b1, MSBI'(8'hB0 + i), 1'b0, 1'b0);
        repeat (9) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_level", LEVEL, 7);
        chk("pre_rst_ovf", OVF, 1);
        do_reset();
        cycle(1'b1, 8'h99, 1'b1, 1'b0);
        chk("post_rst_ignored", OVALID, 0);
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("post_rst_ovalid", OVALID, 1);
        chk("post_rst_odata", ODATA, 8'h5A);
        chk("post_rst_level", LEVEL, 0);
        $display("seq mid-run reset done");

        // Randomized traffic against the model
        pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) pct = (($urandom % 3) == 0) ? 10 : ((($urandom % 2) == 0) ? 50 : 90);
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom % 100) < 60, MSBI'($urandom), ($urandom % 100) < pct,
                      ($urandom % 100) < 3);
            end
        end
        $display("seq random done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
